// File: rtl/tic_tac_toe_pkg.sv
// Shared cell codes, FSM state encoding and board size for the move-legality path.
package tic_tac_toe_pkg;

    localparam int N_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [2:0] ST_P1_TURN   = 3'd0;
    localparam logic [2:0] ST_P1_COMMIT = 3'd1;
    localparam logic [2:0] ST_P2_TURN   = 3'd2;
    localparam logic [2:0] ST_P2_COMMIT = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

endpackage

// File: rtl/position_code_decoder.sv
// Combinational position code (1..9) to one-hot cell select; valid low for any other code.
module position_code_decoder
    import tic_tac_toe_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic [CODE_W-1:0]  code,
    output logic [N_CELLS:1]   onehot,
    output logic               valid
);

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        for (int k = 1; k <= N_CELLS; k++) begin
            if (code == CODE_W'(k)) begin
                onehot[k] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_move_committer.sv
// Captures player move requests, presents one-hot enables to the illegal-move detector for one
// cycle, and commits legal moves into the position registers; owns turn order and game-over lockout.
module board_move_committer
    import tic_tac_toe_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play,
    input  logic              player2,
    input  logic [CODE_W-1:0] pos_code,
    input  logic              illegal_move,
    input  logic              win,
    output logic [1:0]        pos1,
    output logic [1:0]        pos2,
    output logic [1:0]        pos3,
    output logic [1:0]        pos4,
    output logic [1:0]        pos5,
    output logic [1:0]        pos6,
    output logic [1:0]        pos7,
    output logic [1:0]        pos8,
    output logic [1:0]        pos9,
    output logic [9:1]        PL_en,
    output logic [9:1]        PL2_en,
    output logic              turn,
    output logic [CNT_W-1:0]  move_count,
    output logic              illegal_flag,
    output logic              game_over
);

    logic [2:0]         state;
    logic [1:0]         cells [1:N_CELLS];
    logic               play_d;
    logic               player2_d;
    logic               armed;
    logic               req1;
    logic               req2;
    logic [N_CELLS:1]   code_onehot;
    logic               code_valid;

    position_code_decoder #(.CODE_W(CODE_W)) u_decoder (
        .code   (pos_code),
        .onehot (code_onehot),
        .valid  (code_valid)
    );

    // armed stays low for the first cycle after reset so a button held through release reads as
    // already pressed rather than as a fresh edge
    assign req1 = armed & play    & ~play_d;
    assign req2 = armed & player2 & ~player2_d;

    assign pos1 = cells[1];
    assign pos2 = cells[2];
    assign pos3 = cells[3];
    assign pos4 = cells[4];
    assign pos5 = cells[5];
    assign pos6 = cells[6];
    assign pos7 = cells[7];
    assign pos8 = cells[8];
    assign pos9 = cells[9];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_P1_TURN;
            play_d       <= 1'b0;
            player2_d    <= 1'b0;
            armed        <= 1'b0;
            PL_en        <= '0;
            PL2_en       <= '0;
            turn         <= 1'b0;
            move_count   <= '0;
            illegal_flag <= 1'b0;
            game_over    <= 1'b0;
            for (int k = 1; k <= N_CELLS; k++) cells[k] <= CELL_EMPTY;
        end else begin
            play_d    <= play;
            player2_d <= player2;
            armed     <= 1'b1;
            case (state)
                ST_P1_TURN: begin
                    if (win || move_count == CNT_W'(N_CELLS)) begin
                        state     <= ST_GAME_OVER;
                        game_over <= 1'b1;
                    end else if (req2) begin
                        illegal_flag <= 1'b1;
                    end else if (req1) begin
                        if (!code_valid) begin
                            illegal_flag <= 1'b1;
                        end else begin
                            PL_en <= code_onehot;
                            state <= ST_P1_COMMIT;
                        end
                    end
                end
                ST_P1_COMMIT: begin
                    PL_en <= '0;
                    if (!illegal_move) begin
                        for (int k = 1; k <= N_CELLS; k++) if (PL_en[k]) cells[k] <= CELL_P1;
                        move_count   <= move_count + CNT_W'(1);
                        illegal_flag <= 1'b0;
                        turn         <= 1'b1;
                        state        <= ST_P2_TURN;
                    end else begin
                        illegal_flag <= 1'b1;
                        state        <= ST_P1_TURN;
                    end
                end
                ST_P2_TURN: begin
                    if (win || move_count == CNT_W'(N_CELLS)) begin
                        state     <= ST_GAME_OVER;
                        game_over <= 1'b1;
                    end else if (req1) begin
                        illegal_flag <= 1'b1;
                    end else if (req2) begin
                        if (!code_valid) begin
                            illegal_flag <= 1'b1;
                        end else begin
                            PL2_en <= code_onehot;
                            state  <= ST_P2_COMMIT;
                        end
                    end
                end
                ST_P2_COMMIT: begin
                    PL2_en <= '0;
                    if (!illegal_move) begin
                        for (int k = 1; k <= N_CELLS; k++) if (PL2_en[k]) cells[k] <= CELL_P2;
                        move_count   <= move_count + CNT_W'(1);
                        illegal_flag <= 1'b0;
                        turn         <= 1'b0;
                        state        <= ST_P1_TURN;
                    end else begin
                        illegal_flag <= 1'b1;
                        state        <= ST_P2_TURN;
                    end
                end
                ST_GAME_OVER: begin
                    game_over <= 1'b1;
                end
                default: state <= ST_P1_TURN;
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_committer.sv
// Directed bench: stimulus queues expected commit-cycle enables and post-commit board state; a monitor checks them.
module tb_board_move_committer;

    logic       clock;
    logic       reset;
    logic       play;
    logic       player2;
    logic [3:0] pos_code;
    logic       illegal_move;
    logic       win;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [9:1] PL_en;
    logic [9:1] PL2_en;
    logic       turn;
    logic [3:0] move_count;
    logic       illegal_flag;
    logic       game_over;

    board_move_committer #(.CODE_W(4), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .play         (play),
        .player2      (player2),
        .pos_code     (pos_code),
        .illegal_move (illegal_move),
        .win          (win),
        .pos1         (pos1),
        .pos2         (pos2),
        .pos3         (pos3),
        .pos4         (pos4),
        .pos5         (pos5),
        .pos6         (pos6),
        .pos7         (pos7),
        .pos8         (pos8),
        .pos9         (pos9),
        .PL_en        (PL_en),
        .PL2_en       (PL2_en),
        .turn         (turn),
        .move_count   (move_count),
        .illegal_flag (illegal_flag),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic [8:0]  pl;
        logic [8:0]  pl2;
        logic [17:0] cells;
        logic        turn;
        logic [3:0]  cnt;
        logic        flag;
        logic        go;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // reference board state
    logic [1:0] mcell [1:9];
    logic       mturn;
    logic [3:0] mcnt;
    logic       mflag;
    logic       mgo;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [17:0] model_cells();
        logic [17:0] v;
        for (int k = 1; k <= 9; k++) v[2*k-1 -: 2] = mcell[k];
        return v;
    endfunction

    function automatic logic [17:0] dut_cells();
        return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 9; k++) mcell[k] = 2'b00;
        mturn = 1'b0;
        mcnt  = 4'd0;
        mflag = 1'b0;
        mgo   = 1'b0;
    endtask

    task automatic check_state(input string name);
        logic [42:0] got, want;
        got  = {dut_cells(), turn, move_count, illegal_flag, game_over, PL_en, PL2_en};
        want = {model_cells(), mturn, mcnt, mflag, mgo, 9'd0, 9'd0};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got {cells,turn,cnt,flag,go,PL,PL2}=%h expected %h", name, got, want);
        end
    endtask

    // Scoreboard monitor: any cycle with an enable asserted must match the head entry, and the
    // cycle after it must show the queued post-commit state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock); #1;
            if (PL_en != 9'd0 || PL2_en != 9'd0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_enable: got PL_en=%b PL2_en=%b expected no enable", PL_en, PL2_en);
                end else begin
                    e = exp_q.pop_front();
                    if ({PL_en, PL2_en} !== {e.pl, e.pl2}) begin
                        n_fail++;
                        $display("FAIL commit_enable: got PL_en=%b PL2_en=%b expected %b %b",
                                 PL_en, PL2_en, e.pl, e.pl2);
                    end
                    @(posedge clock); #1;
                    n_cmp++;
                    if ({dut_cells(), turn, move_count, illegal_flag, game_over, PL_en, PL2_en} !==
                        {e.cells, e.turn, e.cnt, e.flag, e.go, 18'd0}) begin
                        n_fail++;
                        $display("FAIL post_commit: got cells=%h turn=%0d cnt=%0d flag=%0d go=%0d PL=%b PL2=%b expected cells=%h turn=%0d cnt=%0d flag=%0d go=%0d",
                                 dut_cells(), turn, move_count, illegal_flag, game_over, PL_en, PL2_en,
                                 e.cells, e.turn, e.cnt, e.flag, e.go);
                    end
                end
            end
        end
    end

    // Issue one request (b1 = play, b2 = player2), update the model, then check the settled state.
    task automatic req(input bit b1, input bit b2, input logic [3:0] code, input bit ill, input string name);
        exp_t       e;
        logic [8:0] oh;
        bit         p2;
        if (!mgo) begin
            if (b1 && b2) begin
                mflag = 1'b1;
            end else if (b1 || b2) begin
                p2 = b2;
                if (p2 != mturn) mflag = 1'b1;
                else if (code < 1 || code > 9) mflag = 1'b1;
                else begin
                    oh    = 9'd1 << (code - 1);
                    e.pl  = p2 ? 9'd0 : oh;
                    e.pl2 = p2 ? oh : 9'd0;
                    if (!ill) begin
                        mcell[code] = p2 ? 2'b10 : 2'b01;
                        mcnt  = mcnt + 4'd1;
                        mflag = 1'b0;
                        mturn = ~mturn;
                    end else begin
                        mflag = 1'b1;
                    end
                    e.cells = model_cells();
                    e.turn  = mturn;
                    e.cnt   = mcnt;
                    e.flag  = mflag;
                    e.go    = 1'b0;
                    exp_q.push_back(e);
                    if (mcnt == 4'd9) mgo = 1'b1;
                end
            end
        end
        @(negedge clock);
        pos_code     = code;
        illegal_move = ill;
        play         = b1;
        player2      = b2;
        repeat (3) @(negedge clock);
        play    = 1'b0;
        player2 = 1'b0;
        @(negedge clock);
        illegal_move = 1'b0;
        check_state(name);
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check_state(name);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        exp_t e;
        reset        = 1'b1;
        play         = 1'b0;
        player2      = 1'b0;
        pos_code     = 4'd0;
        illegal_move = 1'b0;
        win          = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_state("reset_hold");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_state("reset_release");

        // Game A: detector rejection, malformed requests, full board
        req(1, 0, 4'd5,  0, "a_p1_5");
        req(0, 1, 4'd5,  1, "a_p2_5_detector_illegal");
        req(0, 1, 4'd3,  0, "a_p2_3");
        req(1, 1, 4'd1,  0, "a_both_rise");
        req(1, 0, 4'd1,  0, "a_p1_1");
        req(0, 1, 4'd2,  0, "a_p2_2");
        req(0, 1, 4'd4,  0, "a_p2_wrong_turn");
        req(1, 0, 4'd7,  0, "a_p1_7");
        req(0, 1, 4'd8,  0, "a_p2_8");
        req(1, 0, 4'd0,  0, "a_p1_code0");
        req(1, 0, 4'd4,  0, "a_p1_4");
        req(0, 1, 4'd6,  0, "a_p2_6");
        req(1, 0, 4'd12, 0, "a_p1_code12");
        req(1, 0, 4'd9,  0, "a_p1_9_full");
        req(0, 1, 4'd1,  0, "a_over_p2");
        req(1, 0, 4'd2,  0, "a_over_p1");

        // Game B: win lockout from player-2's turn
        do_reset("b_reset");
        req(1, 0, 4'd1, 0, "b_p1_1");
        @(negedge clock);
        win = 1'b1;
        @(negedge clock);
        win = 1'b0;
        mgo = 1'b1;
        @(negedge clock);
        check_state("b_win");
        req(0, 1, 4'd5, 0, "b_p2_after_win");

        // Game C: reset during commit, button held across release
        do_reset("c_reset");
        @(negedge clock);
        pos_code     = 4'd7;
        illegal_move = 1'b0;
        play         = 1'b1;
        e.pl  = 9'd1 << 6;
        e.pl2 = 9'd0;
        e.cells = 18'd0;
        e.turn  = 1'b0;
        e.cnt   = 4'd0;
        e.flag  = 1'b0;
        e.go    = 1'b0;
        exp_q.push_back(e);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check_state("c_reset_mid_commit");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_state("c_play_held_over_release");
        play = 1'b0;
        @(negedge clock);
        req(1, 0, 4'd7, 0, "c_p1_7_after_reset");
        repeat (3) @(negedge clock);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending commits expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
